// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the cumulative 1..10 adder controller.
// Optional single-step gating is enabled with the ADDER_CTRL_STEP_EN macro.
package adder_ctrl_pkg;

   localparam int ADDR_W = 3;

   localparam logic [ADDR_W-1:0] ADDR_ZERO = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_I    = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_SUM  = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = 3'd3;

   localparam logic SEL_ADDER = 1'b0;
   localparam logic SEL_ONE   = 1'b1;

   typedef enum logic [3:0] {
      IDLE,
      INIT_I,
      INIT_SUM,
      INIT_ONE,
      CMP,
      ADD,
      INC,
      OUT,
      DONE
   } state_e;

   typedef struct packed {
      logic              sel;
      logic [ADDR_W-1:0] rd_addr1;
      logic [ADDR_W-1:0] rd_addr2;
      logic [ADDR_W-1:0] wr_addr;
      logic              wr_en;
      logic              out_buf;
   } ctrl_word_t;

   // A run is in progress in every state except IDLE and DONE.
   function automatic logic is_active(state_e s);
      return (s != IDLE) && (s != DONE);
   endfunction

endpackage

// File: rtl/adder_ctrl_if.sv
// Controller <-> datapath bundle. The step input exists only with ADDER_CTRL_STEP_EN.
// start and step are levels sampled on the rising clock edge; there is no ready back-pressure.
interface adder_ctrl_if;
   import adder_ctrl_pkg::*;

   logic              start;
   logic              iLe10;
`ifdef ADDER_CTRL_STEP_EN
   logic              step;
`endif
   logic              RFSrcMuxSel;
   logic [ADDR_W-1:0] readAddr1;
   logic [ADDR_W-1:0] readAddr2;
   logic [ADDR_W-1:0] writeAddr;
   logic              writeEn;
   logic              outBuf;
   logic              busy;
   logic              done;

   modport master (
      input  start,
      input  iLe10,
`ifdef ADDER_CTRL_STEP_EN
      input  step,
`endif
      output RFSrcMuxSel,
      output readAddr1,
      output readAddr2,
      output writeAddr,
      output writeEn,
      output outBuf,
      output busy,
      output done
   );

   modport slave (
      output start,
      output iLe10,
`ifdef ADDER_CTRL_STEP_EN
      output step,
`endif
      input  RFSrcMuxSel,
      input  readAddr1,
      input  readAddr2,
      input  writeAddr,
      input  writeEn,
      input  outBuf,
      input  busy,
      input  done
   );

endinterface

// File: rtl/adder_ctrl_decode.sv
// Combinational decode of the controller state into datapath control fields.
module adder_ctrl_decode
   import adder_ctrl_pkg::*;
(
   input  state_e     state,
   output ctrl_word_t ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         INIT_I: begin
            ctrl.sel     = SEL_ONE;
            ctrl.wr_addr = ADDR_I;
            ctrl.wr_en   = 1'b1;
         end
         INIT_SUM: begin
            // R0 + R0 through the adder clears the running sum.
            ctrl.sel      = SEL_ADDER;
            ctrl.rd_addr1 = ADDR_ZERO;
            ctrl.rd_addr2 = ADDR_ZERO;
            ctrl.wr_addr  = ADDR_SUM;
            ctrl.wr_en    = 1'b1;
         end
         INIT_ONE: begin
            ctrl.sel     = SEL_ONE;
            ctrl.wr_addr = ADDR_ONE;
            ctrl.wr_en   = 1'b1;
         end
         CMP: begin
            ctrl.rd_addr1 = ADDR_I;
         end
         ADD: begin
            ctrl.sel      = SEL_ADDER;
            ctrl.rd_addr1 = ADDR_SUM;
            ctrl.rd_addr2 = ADDR_I;
            ctrl.wr_addr  = ADDR_SUM;
            ctrl.wr_en    = 1'b1;
         end
         INC: begin
            ctrl.sel      = SEL_ADDER;
            ctrl.rd_addr1 = ADDR_I;
            ctrl.rd_addr2 = ADDR_ONE;
            ctrl.wr_addr  = ADDR_I;
            ctrl.wr_en    = 1'b1;
         end
         OUT: begin
            ctrl.rd_addr1 = ADDR_SUM;
            ctrl.out_buf  = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/adder_ctrl_unit.sv
// Moore control FSM for the cumulative 1..10 adder (final sum 55).
// Define ADDER_CTRL_STEP_EN to make every active state advance only on step=1.
module adder_ctrl_unit
   import adder_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   adder_ctrl_if.master  bus,
   output state_e        dbg_state
);

   state_e     state_q;
   state_e     state_d;
   ctrl_word_t ctrl;
   logic       advance;
   logic       hold;

`ifdef ADDER_CTRL_STEP_EN
   assign advance = bus.step;
`else
   assign advance = 1'b1;
`endif

   // IDLE and DONE never stall; only the active states wait for step.
   assign hold = is_active(state_q) && !advance;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (bus.start) state_d = INIT_I;
         INIT_I:   state_d = INIT_SUM;
         INIT_SUM: state_d = INIT_ONE;
         INIT_ONE: state_d = CMP;
         CMP:      state_d = bus.iLe10 ? ADD : DONE;
         ADD:      state_d = INC;
         INC:      state_d = OUT;
         OUT:      state_d = CMP;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      if (hold) state_d = state_q;
   end

   adder_ctrl_decode u_decode (
      .state (state_q),
      .ctrl  (ctrl)
   );

   // A held state keeps addresses driven but must not write or load twice.
   assign bus.RFSrcMuxSel = ctrl.sel;
   assign bus.readAddr1   = ctrl.rd_addr1;
   assign bus.readAddr2   = ctrl.rd_addr2;
   assign bus.writeAddr   = ctrl.wr_addr;
   assign bus.writeEn     = ctrl.wr_en & ~hold;
   assign bus.outBuf      = ctrl.out_buf & ~hold;
   assign bus.busy        = is_active(state_q);
   assign bus.done        = (state_q == DONE);
   assign dbg_state       = state_q;

endmodule
